uart_cmd_bridge: RTL and testbench
==================================

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 24, memory address width; always sent as 3 address bytes.
- DATA_W, 16, memory data width; always sent as 2 data bytes.
- TIMEOUT_CYC, 1_330_000, maximum clk cycles allowed between bytes inside a frame.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning (clock and reset first).
- clk, in, 1, single clock for all logic.
- reset, in, 1, synchronous, active-high.
- uart_rdata, in, 8, head byte of the UART receive FIFO; valid while uart_rx_empty=0.
- uart_rx_empty, in, 1, receive FIFO empty.
- uart_rd, out, 1, one-cycle pop of the receive FIFO.
- uart_wdata, out, 8, byte pushed into the UART transmit FIFO.
- uart_wr, out, 1, one-cycle push into the transmit FIFO.
- uart_tx_full, in, 1, transmit FIFO full.
- mem_req, out, 1, memory request; held high until mem_ack.
- mem_we, out, 1, 1 = write, 0 = read; stable while mem_req=1.
- mem_addr, out, ADDR_W, request address; stable while mem_req=1.
- mem_wdata, out, DATA_W, write data; stable while mem_req=1.
- mem_ack, in, 1, one-cycle completion strobe from memory.
- mem_rdata, in, DATA_W, read data; valid in the mem_ack cycle.
- busy, out, 1, high whenever the state is not IDLE.
- err_tick, out, 1, one-cycle pulse on a bad opcode or a timeout.
REQ-003 Clocking and reset SHALL be one clock (clk) and a synchronous, active-high reset (reset).

Function
REQ-004 Frame formats SHALL be:
- Write: 0x57, A2, A1, A0, D1, D0.
- Read: 0x52, A2, A1, A0.
- Multi-byte fields are MSB first.
REQ-005 The state machine SHALL have states IDLE, ADDR, WDATA, REQ, RESP, ERR.
REQ-006 Byte acceptance: in any state that receives bytes, if uart_rx_empty=0, the block SHALL assert uart_rd for one cycle and capture uart_rdata in that same cycle.
REQ-007 After each pop, the block SHALL NOT pop in the following cycle, so there are at most 1 pop per 2 cycles.
REQ-008 IDLE transitions on the received byte:
- 0x57 or 0x52: latch mem_we (1 for 0x57, 0 for 0x52), go to ADDR.
- Any other byte: go to ERR.
REQ-009 ADDR SHALL collect 3 bytes into mem_addr, then go to WDATA if mem_we=1, else to REQ.
REQ-010 WDATA SHALL collect 2 bytes into mem_wdata, then go to REQ.
REQ-011 REQ behaviour:
- mem_req goes high on entry and stays high until the cycle mem_ack=1, then drops the next cycle.
- Exit is to RESP.
- mem_ack arriving when mem_req=0 SHALL be ignored.
REQ-012 On the mem_ack of a read, mem_rdata SHALL be latched into a response register.
REQ-013 RESP responses:
- After a write: push 0x4B.
- After a read: push D1, then D0.
REQ-014 Each push SHALL occur only in a cycle with uart_tx_full=0; otherwise the block stalls with uart_wr=0 and the byte held.
REQ-015 After the last push, the state SHALL return to IDLE.
REQ-016 ERR SHALL pulse err_tick, push 0x3F (waiting while uart_tx_full=1), then return to IDLE.
REQ-017 Inter-byte timeout:
- A counter clears on every pop and on entry to ADDR.
- If it reaches TIMEOUT_CYC while in ADDR or WDATA, the block pulses err_tick, pushes nothing, discards the partial frame and goes to IDLE.
- The counter SHALL be unused in other states.
REQ-018 Bytes arriving during REQ or RESP SHALL stay in the receive FIFO, unread, until IDLE.
REQ-019 Same-cycle events: in a cycle where the timeout and a non-empty receive FIFO coincide, the byte SHALL win (pop and counter clear), and the timeout SHALL NOT fire.
REQ-020 uart_rd and uart_wr SHALL never be high in the same cycle for the same state, and each SHALL be a registered output.

Reset
REQ-021 On reset=1 at a clk edge:
- State goes to IDLE.
- uart_rd, uart_wr, mem_req, mem_we, busy and err_tick go to 0.
- mem_addr, mem_wdata, uart_wdata, the response register and the timeout counter go to 0.
REQ-022 Reset during REQ SHALL drop mem_req the next cycle and SHALL NOT issue a response.
REQ-023 Reset in any state SHALL discard the partial frame, and a mem_ack arriving after reset SHALL be ignored.

Verification
REQ-024 Write path: feed 57 01 02 03 BE EF -> one mem_req with mem_we=1, mem_addr=0x010203, mem_wdata=0xBEEF; after mem_ack, exactly one push of 0x4B.
REQ-025 Read path: feed 52 00 00 10; return mem_ack with mem_rdata=0x1234 after 5 cycles -> pushes 0x12 then 0x34; mem_req high for exactly 5 cycles.
REQ-026 Bad opcode: feed 0xAA -> err_tick pulses once, 0x3F is pushed, busy=0 afterwards; a following 52 frame completes normally.
REQ-027 Timeout: feed 57 01 only, with TIMEOUT_CYC=50 -> err_tick fires 50 cycles after the last pop, no mem_req, return to IDLE.
REQ-028 Backpressure: hold uart_tx_full=1 for 20 cycles during a read response -> no uart_wr while full; both data bytes are pushed in order after release.
REQ-029 Reset mid-request: assert reset while mem_req=1, then pulse mem_ack -> mem_req=0 and busy=0, no push, and no second request is issued.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// Byte-framed UART command bridge: decodes 'W'/'R' frames into single memory
// requests and answers with an ack byte, the read data, or '?' on a bad opcode.
module uart_cmd_bridge #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1_330_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        uart_rdata,
  input  logic              uart_rx_empty,
  output logic              uart_rd,
  output logic [7:0]        uart_wdata,
  output logic              uart_wr,
  input  logic              uart_tx_full,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err_tick
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, REQ, RESP, ERR} state_t;

  state_t              state_q, state_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   mdata_q, mdata_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic                timeout;
  logic [15:0]         resp16;

  assign resp16 = 16'(resp_q);

  // cnt_q holds the number of cycles since the last pop (the pop cycle itself is 0)
  assign timeout = (state_q == ADDR || state_q == WDATA) && !rd_q && uart_rx_empty &&
                   (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    mdata_d = mdata_q;
    resp_d  = resp_q;
    err_d   = 1'b0;
    idx_d   = idx_q;
    cnt_d   = '0;

    // The FIFO empty flag is stale during a pop cycle, so never pop back-to-back.
    if ((state_q == IDLE || state_q == ADDR || state_q == WDATA) && !rd_q && !uart_rx_empty)
      rd_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (rd_q) begin
          if (uart_rdata == 8'h57 || uart_rdata == 8'h52) begin
            we_d    = (uart_rdata == 8'h57);
            addr_d  = '0;
            idx_d   = 2'd0;
            state_d = ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      ADDR: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rd_q) begin
          addr_d = ADDR_W'({addr_q, uart_rdata});
          if (idx_q == 2'd2) begin
            idx_d = 2'd0;
            if (we_q) begin
              state_d = WDATA;
            end else begin
              req_d   = 1'b1;
              state_d = REQ;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      WDATA: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rd_q) begin
          mdata_d = DATA_W'({mdata_q, uart_rdata});
          if (idx_q == 2'd1) begin
            idx_d   = 2'd0;
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      REQ: begin
        if (req_q && mem_ack) begin
          req_d   = 1'b0;
          state_d = RESP;
          if (!we_q) resp_d = mem_rdata;
        end
      end
      RESP: begin
        // A push completes in the cycle wr_q is high; the next byte is decided after it.
        if (wr_q) begin
          if (we_q || idx_q == 2'd1) begin
            idx_d   = 2'd0;
            state_d = IDLE;
          end else begin
            idx_d = 2'd1;
          end
        end else if (!uart_tx_full) begin
          wr_d    = 1'b1;
          wdata_d = we_q ? 8'h4B : ((idx_q == 2'd0) ? resp16[15:8] : resp16[7:0]);
        end
      end
      ERR: begin
        if (wr_q) begin
          state_d = IDLE;
        end else if (!uart_tx_full) begin
          wr_d    = 1'b1;
          wdata_d = 8'h3F;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == ADDR || state_d == WDATA)
      cnt_d = rd_q ? CNT_W'(1) : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      mdata_q <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      mdata_q <= mdata_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign uart_rd    = rd_q;
  assign uart_wr    = wr_q;
  assign uart_wdata = wdata_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = mdata_q;
  assign err_tick   = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge: FIFO/memory models, a directed frame table,
// hand-written timeout/backpressure/reset sequences and a random frame stream.
module tb_uart_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  uart_rdata = 8'h00;
  logic        uart_rx_empty = 1'b1;
  logic        uart_rd;
  logic [7:0]  uart_wdata;
  logic        uart_wr;
  logic        uart_tx_full = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        busy;
  logic        err_tick;

  uart_cmd_bridge #(.ADDR_W(24), .DATA_W(16), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .reset(reset),
    .uart_rdata(uart_rdata), .uart_rx_empty(uart_rx_empty), .uart_rd(uart_rd),
    .uart_wdata(uart_wdata), .uart_wr(uart_wr), .uart_tx_full(uart_tx_full),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .err_tick(err_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
  } req_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] rxq[$];
  logic [7:0] txlog[$];
  req_t       reqlog[$];
  bit   rd_pend = 0;
  bit   req_prev = 0;
  bit   ack_sent = 0;
  bit   auto_ack = 1;
  bit   rand_lat = 0;
  bit   hold_on_ack = 0;
  int   ack_lat = 1;
  int   req_len = 0;
  int   last_req_len = 0;
  int   full_hold = 0;
  int   full_pct = 0;
  int   full_rel_cyc = 0;
  int   first_push_cyc = -1;
  int   last_pop_cyc = 0;
  int   err_cyc = 0;
  int   err_cnt = 0;
  int   viol = 0;
  req_t cur;
  logic [15:0] mem_store [int];

  function automatic logic [15:0] mem_default(input logic [23:0] a);
    return a[15:0] ^ 16'h6C3A;
  endfunction

  function automatic logic [7:0] tx_at(input int i);
    return (i < txlog.size()) ? txlog[i] : 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: observe DUT outputs at the falling edge, then drive the next inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rd_pend) begin
      if (rxq.size() > 0) rxq.delete(0);
      rd_pend = 0;
    end
    if (uart_rd) begin
      rd_pend = 1;
      last_pop_cyc = cyc;
    end
    if (uart_rd && uart_wr) viol++;
    if (uart_wr) begin
      if (uart_tx_full) viol++;
      txlog.push_back(uart_wdata);
      if (first_push_cyc < 0) first_push_cyc = cyc;
    end
    if (err_tick) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (mem_req) begin
      if (!req_prev) begin
        cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
        reqlog.push_back(cur);
        req_len = 0;
        ack_sent = 0;
        if (rand_lat) ack_lat = $urandom_range(1, 6);
      end else if (mem_we !== cur.we || mem_addr !== cur.addr || mem_wdata !== cur.wdata) begin
        viol++;
      end
      req_len++;
    end else if (req_prev) begin
      last_req_len = req_len;
    end
    req_prev = mem_req;

    mem_ack = 1'b0;
    mem_rdata = 16'($urandom);
    if (auto_ack && mem_req && !ack_sent && req_len >= ack_lat) begin
      mem_ack = 1'b1;
      ack_sent = 1;
      if (mem_we) mem_store[int'(mem_addr)] = mem_wdata;
      else mem_rdata = mem_store.exists(int'(mem_addr)) ? mem_store[int'(mem_addr)]
                                                        : mem_default(mem_addr);
      if (hold_on_ack) begin
        full_hold = 20;
        hold_on_ack = 0;
      end
    end

    if (full_hold > 0) begin
      uart_tx_full = 1'b1;
      full_hold--;
      if (full_hold == 0) full_rel_cyc = cyc;
    end else if (uart_wr) begin
      uart_tx_full = 1'b0;
    end else begin
      uart_tx_full = ($urandom_range(0, 99) < full_pct);
    end

    uart_rx_empty = (rxq.size() == 0);
    uart_rdata = (rxq.size() != 0) ? rxq[0] : 8'($urandom);
  endtask

  task automatic run_idle(input string nm, input int budget);
    int n;
    n = 0;
    step();
    while ((rxq.size() != 0 || rd_pend || busy || mem_req || uart_wr) && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    chk({nm, "_done"}, n < budget, 1);
  endtask

  task automatic clear_logs();
    txlog.delete();
    reqlog.delete();
    err_cnt = 0;
    first_push_cyc = -1;
    viol = 0;
  endtask

  typedef struct {
    logic [47:0] bytes;
    int          nb;
    int          lat;
    logic [15:0] rdata;
    int          nreq;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    int          npush;
    logic [7:0]  p0;
    logic [7:0]  p1;
    int          nerr;
  } vec_t;

  vec_t vt[8];
  logic [23:0] addr_tab[4];
  logic [7:0]  exp_tx[$];
  req_t        exp_req[$];
  logic [15:0] ref_mem [int];

  initial begin
    int n;
    int exp_err;
    int kind;
    logic [23:0] a;
    logic [15:0] d;
    logic [7:0]  b;
    req_t r;

    vt[0] = '{48'h570102_03BEEF, 6, 1, 16'h0000, 1, 1'b1, 24'h010203, 16'hBEEF, 1, 8'h4B, 8'h00, 0};
    vt[1] = '{48'h520000_100000, 4, 5, 16'h1234, 1, 1'b0, 24'h000010, 16'h0000, 2, 8'h12, 8'h34, 0};
    vt[2] = '{48'hAA0000_000000, 1, 1, 16'h0000, 0, 1'b0, 24'h000000, 16'h0000, 1, 8'h3F, 8'h00, 1};
    vt[3] = '{48'h52ABCD_EF0000, 4, 2, 16'h8001, 1, 1'b0, 24'hABCDEF, 16'h0000, 2, 8'h80, 8'h01, 0};
    vt[4] = '{48'h57FFFF_FF0000, 6, 3, 16'h0000, 1, 1'b1, 24'hFFFFFF, 16'h0000, 1, 8'h4B, 8'h00, 0};
    vt[5] = '{48'h000000_000000, 1, 1, 16'h0000, 0, 1'b0, 24'h000000, 16'h0000, 1, 8'h3F, 8'h00, 1};
    vt[6] = '{48'h770000_000000, 1, 1, 16'h0000, 0, 1'b0, 24'h000000, 16'h0000, 1, 8'h3F, 8'h00, 1};
    vt[7] = '{48'h52FFFF_FF0000, 4, 1, 16'hC35A, 1, 1'b0, 24'hFFFFFF, 16'h0000, 2, 8'hC3, 8'h5A, 0};

    // Reset values
    step();
    step();
    chk("rst_rd", uart_rd, 0);
    chk("rst_wr", uart_wr, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_tick, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_txdata", uart_wdata, 0);
    reset = 1'b0;
    step();

    // Directed frame table
    for (int k = 0; k < 8; k++) begin
      clear_logs();
      ack_lat = vt[k].lat;
      if (vt[k].nreq != 0 && !vt[k].we) mem_store[int'(vt[k].addr)] = vt[k].rdata;
      for (int i = 0; i < vt[k].nb; i++) rxq.push_back(vt[k].bytes[47-8*i -: 8]);
      run_idle($sformatf("vec%0d", k), 500);
      chk($sformatf("vec%0d_nreq", k), reqlog.size(), vt[k].nreq);
      if (reqlog.size() != 0 && vt[k].nreq != 0) begin
        chk($sformatf("vec%0d_we", k), reqlog[0].we, vt[k].we);
        chk($sformatf("vec%0d_addr", k), reqlog[0].addr, vt[k].addr);
        if (vt[k].we) chk($sformatf("vec%0d_wdata", k), reqlog[0].wdata, vt[k].wdata);
        chk($sformatf("vec%0d_reqlen", k), last_req_len, vt[k].lat);
      end
      chk($sformatf("vec%0d_npush", k), txlog.size(), vt[k].npush);
      chk($sformatf("vec%0d_p0", k), tx_at(0), vt[k].p0);
      if (vt[k].npush == 2) chk($sformatf("vec%0d_p1", k), tx_at(1), vt[k].p1);
      chk($sformatf("vec%0d_err", k), err_cnt, vt[k].nerr);
      chk($sformatf("vec%0d_busy", k), busy, 0);
      chk($sformatf("vec%0d_proto", k), viol, 0);
    end

    // Timeout after a partial write frame
    clear_logs();
    rxq.push_back(8'h57); rxq.push_back(8'h01);
    n = 0;
    while (err_cnt == 0 && n < 300) begin step(); n++; end
    chk("to_fired", n < 300, 1);
    chk("to_gap", err_cyc - last_pop_cyc, 50);
    chk("to_busy", busy, 0);
    repeat (10) step();
    chk("to_nreq", reqlog.size(), 0);
    chk("to_npush", txlog.size(), 0);
    chk("to_errcnt", err_cnt, 1);

    // Byte arriving in the last cycle before the timeout wins
    clear_logs();
    rxq.push_back(8'h57); rxq.push_back(8'h01);
    n = 0;
    while ((rxq.size() != 0 || rd_pend) && n < 100) begin step(); n++; end
    while (cyc < last_pop_cyc + 49 && n < 200) begin step(); n++; end
    rxq.push_back(8'h02); rxq.push_back(8'h03); rxq.push_back(8'hBE); rxq.push_back(8'hEF);
    uart_rx_empty = 1'b0;
    uart_rdata = rxq[0];
    ack_lat = 2;
    run_idle("edge", 500);
    chk("edge_err", err_cnt, 0);
    chk("edge_nreq", reqlog.size(), 1);
    chk("edge_addr", (reqlog.size() != 0) ? reqlog[0].addr : 24'h0, 24'h010203);
    chk("edge_push", tx_at(0), 8'h4B);

    // Transmit backpressure during a read response
    clear_logs();
    mem_store[int'(24'h000010)] = 16'hA1B2;
    hold_on_ack = 1;
    ack_lat = 3;
    rxq.push_back(8'h52); rxq.push_back(8'h00); rxq.push_back(8'h00); rxq.push_back(8'h10);
    run_idle("bp", 500);
    chk("bp_npush", txlog.size(), 2);
    chk("bp_p0", tx_at(0), 8'hA1);
    chk("bp_p1", tx_at(1), 8'hB2);
    chk("bp_after_release", first_push_cyc > full_rel_cyc, 1);
    chk("bp_proto", viol, 0);

    // Reset while a request is outstanding, then a stray ack
    clear_logs();
    auto_ack = 0;
    rxq.push_back(8'h52); rxq.push_back(8'h00); rxq.push_back(8'h00); rxq.push_back(8'h20);
    n = 0;
    while (!mem_req && n < 100) begin step(); n++; end
    chk("rstreq_seen", mem_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstreq_req_drop", mem_req, 0);
    chk("rstreq_busy", busy, 0);
    step();
    mem_ack = 1'b1;
    repeat (20) step();
    chk("rstreq_req_after", mem_req, 0);
    chk("rstreq_busy_after", busy, 0);
    chk("rstreq_npush", txlog.size(), 0);
    chk("rstreq_nreq", reqlog.size(), 1);
    auto_ack = 1;

    // Random frame stream against a frame-level reference
    clear_logs();
    mem_store.delete();
    ref_mem.delete();
    exp_tx.delete();
    exp_req.delete();
    exp_err = 0;
    addr_tab[0] = 24'h000010; addr_tab[1] = 24'h123456; addr_tab[2] = 24'hABCDEF;
    addr_tab[3] = 24'($urandom);
    rand_lat = 1;
    full_pct = 30;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      a = addr_tab[$urandom_range(0, 3)];
      d = 16'($urandom);
      if (kind < 5) begin
        rxq.push_back(8'h57);
        rxq.push_back(a[23:16]); rxq.push_back(a[15:8]); rxq.push_back(a[7:0]);
        rxq.push_back(d[15:8]); rxq.push_back(d[7:0]);
        r.we = 1'b1; r.addr = a; r.wdata = d;
        exp_req.push_back(r);
        ref_mem[int'(a)] = d;
        exp_tx.push_back(8'h4B);
      end else if (kind < 9) begin
        rxq.push_back(8'h52);
        rxq.push_back(a[23:16]); rxq.push_back(a[15:8]); rxq.push_back(a[7:0]);
        r.we = 1'b0; r.addr = a; r.wdata = 16'h0000;
        exp_req.push_back(r);
        d = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_default(a);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
      end else begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        rxq.push_back(b);
        exp_tx.push_back(8'h3F);
        exp_err++;
      end
    end
    run_idle("rnd", 20000);
    chk("rnd_ntx", txlog.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) chk($sformatf("rnd_tx%0d", i), tx_at(i), exp_tx[i]);
    chk("rnd_nreq", reqlog.size(), exp_req.size());
    for (int i = 0; i < exp_req.size() && i < reqlog.size(); i++) begin
      chk($sformatf("rnd_we%0d", i), reqlog[i].we, exp_req[i].we);
      chk($sformatf("rnd_addr%0d", i), reqlog[i].addr, exp_req[i].addr);
      if (exp_req[i].we) chk($sformatf("rnd_wdata%0d", i), reqlog[i].wdata, exp_req[i].wdata);
    end
    chk("rnd_err", err_cnt, exp_err);
    chk("rnd_proto", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
